// File: rtl/lsu_dcache_adapter.sv
`default_nettype none
// ============================================================================
// Module  : lsu_dcache_adapter
// Purpose : memory-stage load/store adapter onto the D$ port (hold, extend, align, watchdog)
// Revision: 1.0
// ============================================================================
module lsu_dcache_adapter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic        dc_en,
  output logic [63:0] dc_in_addr,
  output logic        dc_write_en,
  output logic [63:0] dc_in_wdata,
  output logic [1:0]  dc_in_wlen,
  input  logic [63:0] dc_out_rdata,
  input  logic        dc_out_rvalid,
  input  logic        dc_out_write_done
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_req   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_fault = 2'd3;
  localparam logic [CNT_WIDTH-1:0] c_timeout_last = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]           r_state, w_state_next;
  logic                 r_write, r_unsigned;
  logic [63:0]          r_addr, r_wdata;
  logic [1:0]           r_size;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_resp_valid, r_resp_fault;
  logic [63:0]          r_resp_rdata;
  logic                 w_accept, w_misaligned, w_done, w_timeout, w_busy;
  logic [63:0]          w_load_ext;

  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'd1:    w_misaligned = req_addr[0];
      2'd2:    w_misaligned = |req_addr[1:0];
      2'd3:    w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_accept  = req_valid & req_ready;
  assign w_busy    = (r_state == c_st_req) | (r_state == c_st_drain);
  // Only the done signal matching the latched direction counts.
  assign w_done    = r_write ? dc_out_write_done : dc_out_rvalid;
  assign w_timeout = (r_cnt == c_timeout_last) & ~w_done;

  always_comb begin
    case (r_size)
      2'd0:    w_load_ext = {{56{dc_out_rdata[7]  & ~r_unsigned}}, dc_out_rdata[7:0]};
      2'd1:    w_load_ext = {{48{dc_out_rdata[15] & ~r_unsigned}}, dc_out_rdata[15:0]};
      2'd2:    w_load_ext = {{32{dc_out_rdata[31] & ~r_unsigned}}, dc_out_rdata[31:0]};
      default: w_load_ext = dc_out_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:  if (w_accept) w_state_next = w_misaligned ? c_st_fault : c_st_req;
      c_st_req: begin
        if (w_done || w_timeout) w_state_next = c_st_idle;
        else if (flush)          w_state_next = c_st_drain;
      end
      c_st_drain: if (w_done || w_timeout) w_state_next = c_st_idle;
      default:    w_state_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write    <= req_write;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= req_size;
      end
      if (w_accept)             r_cnt <= '0;
      else if (w_busy && !w_done) r_cnt <= r_cnt + 1'b1;
      // A flush arriving in REQ silences whatever completes or times out.
      r_resp_valid <= (r_state == c_st_req) & ~flush & (w_done | w_timeout);
      r_resp_fault <= (r_state == c_st_req) & ~flush & w_timeout;
      r_resp_rdata <= ((r_state == c_st_req) && !flush && w_done && !r_write) ? w_load_ext : '0;
    end
  end

  always_comb begin
    req_ready   = (r_state == c_st_idle) & ~flush & ~reset;
    dc_en       = w_busy;
    dc_in_addr  = w_busy ? r_addr : '0;
    dc_write_en = w_busy & r_write;
    dc_in_wdata = w_busy ? r_wdata : '0;
    dc_in_wlen  = w_busy ? r_size : '0;
    resp_valid  = r_resp_valid | ((r_state == c_st_fault) & ~flush);
    resp_fault  = r_resp_fault | ((r_state == c_st_fault) & ~flush);
    resp_rdata  = r_resp_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dcache_adapter.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_dcache_adapter
// Purpose : scoreboard bench for lsu_dcache_adapter with a scripted D$ responder
// Revision: 1.0
// ============================================================================
module tb_lsu_dcache_adapter;

  localparam int TIMEOUT_CYCLES = 8;
  localparam int CNT_WIDTH      = 4;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata, resp_rdata, dc_in_addr, dc_in_wdata, dc_out_rdata;
  logic [1:0]  req_size, dc_in_wlen;
  logic        resp_valid, resp_fault, dc_en, dc_write_en, dc_out_rvalid, dc_out_write_done;

  lsu_dcache_adapter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .dc_en(dc_en), .dc_in_addr(dc_in_addr), .dc_write_en(dc_write_en),
    .dc_in_wdata(dc_in_wdata), .dc_in_wlen(dc_in_wlen),
    .dc_out_rdata(dc_out_rdata), .dc_out_rvalid(dc_out_rvalid),
    .dc_out_write_done(dc_out_write_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          at_cyc;
  } resp_t;
  resp_t sb_q[$];
  resp_t mon_e;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_resp", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("resp_rdata", resp_rdata, mon_e.rdata);
        check_val("resp_fault", {63'd0, resp_fault}, {63'd0, mon_e.fault});
        check_val("resp_cycle", 64'(cyc), 64'(mon_e.at_cyc));
      end
    end
  end

  function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [1:0] sz, input logic u);
    int bits = 8 << sz;
    logic [63:0] mask;
    if (sz == 2'd3) return d;
    mask = (64'd1 << bits) - 64'd1;
    if (!u && d[bits-1]) return d | ~mask;
    return d & mask;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one request and returns its accept cycle; leaves us one cycle later.
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic u, output int t);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    req_size = sz; req_unsigned = u;
    #1;
    check_val("req_ready_at_issue", {63'd0, req_ready}, 64'd1);
    t = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_access(input logic w, input logic [63:0] a, input logic [63:0] wd,
                           input logic [1:0] sz, input logic u, input logic [63:0] rd,
                           input int lat, input logic [63:0] exp_rd);
    int t;
    issue(w, a, wd, sz, u, t);
    sb_q.push_back('{exp_rd, 1'b0, t + 2 + lat});
    for (int i = 0; i <= lat; i++) begin
      check_val("hold_dc_en", {63'd0, dc_en}, 64'd1);
      check_val("hold_addr", dc_in_addr, a);
      check_val("hold_write_en", {63'd0, dc_write_en}, {63'd0, w});
      check_val("hold_wdata", dc_in_wdata, wd);
      check_val("hold_wlen", {62'd0, dc_in_wlen}, {62'd0, sz});
      // The wrong-direction done toggles while waiting and must be ignored.
      dc_out_rvalid     = (i == lat) ? ~w : w;
      dc_out_write_done = (i == lat) ? w : ~w;
      dc_out_rdata      = (i == lat) ? rd : 64'hA5A5_A5A5_A5A5_A5A5;
      step();
    end
    dc_out_rvalid = 1'b0; dc_out_write_done = 1'b0;
    check_val("done_dc_en_low", {63'd0, dc_en}, 64'd0);
    check_val("done_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = '0; req_unsigned = 1'b0; dc_out_rdata = '0;
    dc_out_rvalid = 1'b0; dc_out_write_done = 1'b0;
    step(); step();
    check_val("rst_dc_en", {63'd0, dc_en}, 64'd0);
    check_val("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check_val("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check_val("rst_dc_addr", dc_in_addr, 64'd0);
    reset = 1'b0; #1;
    check_val("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    step();

    // Byte load, sign-extended, three wait cycles
    do_access(1'b0, 64'h1003, 64'd0, 2'd0, 1'b0, 64'h1234_5678_9ABC_DE80, 3,
              64'hFFFF_FFFF_FFFF_FF80);
    // Word store with other-done noise
    do_access(1'b1, 64'h2004, 64'hDEAD_BEEF, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'd0);
    // Extension across sizes, including minimum latency
    do_access(1'b0, 64'h3002, 64'd0, 2'd1, 1'b1, 64'h0000_0000_1111_8001, 1,
              ext_model(64'h0000_0000_1111_8001, 2'd1, 1'b1));
    do_access(1'b0, 64'h3002, 64'd0, 2'd1, 1'b0, 64'h0000_0000_1111_8001, 0,
              ext_model(64'h0000_0000_1111_8001, 2'd1, 1'b0));
    do_access(1'b0, 64'h3004, 64'd0, 2'd2, 1'b0, 64'hFFFF_0000_7FFF_FFFF, 1,
              ext_model(64'hFFFF_0000_7FFF_FFFF, 2'd2, 1'b0));
    do_access(1'b0, 64'h3008, 64'd0, 2'd2, 1'b0, 64'h0000_0000_8000_0001, 0,
              ext_model(64'h0000_0000_8000_0001, 2'd2, 1'b0));
    do_access(1'b0, 64'h4008, 64'd0, 2'd3, 1'b1, 64'h8123_4567_89AB_CDEF, 0,
              64'h8123_4567_89AB_CDEF);
    do_access(1'b0, 64'h1000, 64'd0, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 64'hF0);

    // Misaligned halfword load: immediate fault, no D$ request
    issue(1'b0, 64'h3001, 64'd0, 2'd1, 1'b0, t);
    sb_q.push_back('{64'd0, 1'b1, t + 1});
    check_val("misalign_no_dc_en", {63'd0, dc_en}, 64'd0);
    step();
    check_val("misalign_ready_after", {63'd0, req_ready}, 64'd1);

    // Misaligned store killed by flush in its fault cycle: silent
    issue(1'b1, 64'h4004, 64'h55, 2'd3, 1'b0, t);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; req_addr = 64'h7000; req_size = 2'd3; req_write = 1'b0; flush = 1'b1; #1;
    check_val("flush_idle_ready", {63'd0, req_ready}, 64'd0);
    step();
    req_valid = 1'b0; flush = 1'b0;
    check_val("flush_idle_no_dc_en", {63'd0, dc_en}, 64'd0);

    // Flushed doubleword load drains silently
    issue(1'b0, 64'h4000, 64'd0, 2'd3, 1'b0, t);
    flush = 1'b1; #1;
    check_val("flush_req_ready", {63'd0, req_ready}, 64'd0);
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_dc_en", {63'd0, dc_en}, 64'd1);
      check_val("drain_addr", dc_in_addr, 64'h4000);
      check_val("drain_ready", {63'd0, req_ready}, 64'd0);
      if (i == 3) begin dc_out_rvalid = 1'b1; dc_out_rdata = 64'h1234; end
      step();
    end
    dc_out_rvalid = 1'b0;
    check_val("drain_end_dc_en", {63'd0, dc_en}, 64'd0);
    check_val("drain_end_ready", {63'd0, req_ready}, 64'd1);

    // Watchdog: D$ never answers
    issue(1'b0, 64'h5000, 64'd0, 2'd3, 1'b0, t);
    sb_q.push_back('{64'd0, 1'b1, t + 1 + TIMEOUT_CYCLES});
    for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
      check_val("wd_dc_en", {63'd0, dc_en}, 64'd1);
      step();
    end
    check_val("wd_dc_en_drop", {63'd0, dc_en}, 64'd0);
    do_access(1'b0, 64'h5008, 64'd0, 2'd3, 1'b0, 64'h77, 1, 64'h77);

    // Reset in the middle of a request
    issue(1'b0, 64'h6000, 64'd0, 2'd2, 1'b0, t);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; dc_out_rvalid = 1'b1; #1;
    check_val("rst_mid_dc_en", {63'd0, dc_en}, 64'd0);
    check_val("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    step();
    dc_out_rvalid = 1'b0;
    step(); step();

    check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
